alu_seg_disp: RTL and testbench
===============================

// Module: alu_seg_disp
// PURPOSE
//  Downstream display stage for the ALU result: takes the (2*width)-bit unsigned product/sum and
//  the overflow flag, converts binary to 4 BCD digits with a sequential shift-add-3 (double-dabble)
//  engine, then drives seg_4..seg_1 (seg_4 = thousands). Holds the last result until a new one
//  completes, so the 7-seg outputs never flicker mid-conversion.
// PARAMETERS
//  IN_WIDTH  12  result width in bits; legal 1..13 (max 8191 fits in 4 digits)
// PORTS
//  clk        in   1         single system clock, rising edge
//  rst_n      in   1         asynchronous, active-low reset
//  bin        in   IN_WIDTH  unsigned ALU result to display
//  err_in     in   1         ALU overflow; sampled with bin
//  in_valid   in   1         request: bin/err_in are valid this cycle
//  in_ready   out  1         high when the engine can accept; transfer = in_valid & in_ready at an edge
//  bcd        out  16        {thousands,hundreds,tens,ones}, registered
//  done       out  1         one-cycle pulse: bcd/seg updated this cycle
//  seg_4..seg_1 out 7 each   active-low segments, bit order {g,f,e,d,c,b,a}
// BEHAVIOUR
//  - Reset: state IDLE, in_ready=1, done=0, bcd=16'h0000, all seg=7'h7F (blank). Async assert, sync release.
//  - FSM: IDLE --accept--> SHIFT (cnt=IN_WIDTH) --cnt reaches 0--> IDLE. No other states.
//  - Accept edge: load shift reg {16'b0, bin}, latch err_in into err_q, in_ready drops next cycle.
//  - SHIFT, each edge: every BCD nibble >=5 gets +3, then whole reg shifts left 1; cnt--.
//  - Edge of last shift (accept edge + IN_WIDTH): bcd and seg_* registered; next cycle done=1,
//    in_ready=1. Accept-to-done latency = IN_WIDTH+1 cycles (13 for default).
//  - in_valid while in_ready=0 ignored (no queueing, no corruption). New request in the done
//    cycle is accepted: back-to-back throughput one result per IN_WIDTH+1 cycles.
//  - Segment codes: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 (hex), blank=7F.
//  - err_q=1: bcd still holds converted value, but seg_4..1 = E(06) r(2F) r(2F) blank(7F).
//  - rst_n low mid-SHIFT: conversion aborted, outputs return to reset values, no done pulse.
//  - bin changes after accept have no effect on the conversion in flight.
//  - Leading inputs beyond 4 digits impossible by IN_WIDTH limit; no saturation logic.
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN defined: leading zero digits shown blank (7F), ones digit always shown;
//    0 -> "   0", 7 -> "   7", 1204 -> "1204", 40 -> "  40". Err pattern unaffected.
//  Not defined: all four digits always shown, 7 -> "0007". bcd output identical either way.
// TESTING
//  1. Reset, then bin=4095 err=0 valid 1 cycle -> in_ready low 12 cycles, done at +13,
//     bcd=16'h4095, seg_4..1 = 19,40,10,12.
//  2. bin=0 -> bcd=0000; seg = 40,40,40,40 (no macro) / 7F,7F,7F,40 (LEADING_ZERO_BLANK_EN).
//  3. bin=37 err_in=1 -> bcd=0037, seg = 06,2F,2F,7F; next request err_in=0 restores digits.
//  4. Back-to-back: 1234 then 56 with in_valid held high -> second accepted in first done cycle,
//     done pulses 13 cycles apart, bcd 1234 then 0056; extra in_valid while busy ignored.
//  5. Start 999, pull rst_n low at cycle 5 of SHIFT -> seg all 7F, bcd 0, no done; after
//     release, bin=8 converts normally to 0008.
//  6. Random bin 0..4095 x 1000 vs reference model of decimal digits, both macro settings.

Source files
------------

// File: rtl/alu_seg_disp_if.sv
// Bus between the ALU result producer and the alu_seg_disp display stage.
// The master presents a result with in_valid; the slave (display stage)
// answers with in_ready, the registered BCD value, a done pulse and the
// four active-low 7-segment codes.
interface alu_seg_disp_if #(
  parameter int IN_WIDTH = 12
);
  logic [IN_WIDTH-1:0] bin;
  logic                err_in;
  logic                in_valid;
  logic                in_ready;
  logic [15:0]         bcd;
  logic                done;
  logic [6:0]          seg_4;
  logic [6:0]          seg_3;
  logic [6:0]          seg_2;
  logic [6:0]          seg_1;

  modport master (
    output bin, err_in, in_valid,
    input  in_ready, bcd, done, seg_4, seg_3, seg_2, seg_1
  );

  modport slave (
    input  bin, err_in, in_valid,
    output in_ready, bcd, done, seg_4, seg_3, seg_2, seg_1
  );
endinterface

// File: rtl/alu_seg_disp.sv
// alu_seg_disp: converts an unsigned ALU result to 4 BCD digits with a
// sequential double-dabble engine (one bit per cycle) and drives four
// active-low 7-segment digits (seg_4 = thousands, bit order {g,f,e,d,c,b,a}).
// Outputs hold the previous result until a new conversion completes.
// Optional build macro LEADING_ZERO_BLANK_EN: blank leading zero digits
// (ones digit always shown). Without it all four digits are always shown.
module alu_seg_disp #(
  parameter int IN_WIDTH = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_seg_disp_if.slave     bus
);

  localparam int SW = IN_WIDTH + 16;          // shift register: {bcd, bin}
  localparam int CW = $clog2(IN_WIDTH + 1);   // shift counter width

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_R     = 7'h2F;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t          state_q,    state_d;
  logic [CW-1:0]   cnt_q,      cnt_d;
  logic [SW-1:0]   sreg_q,     sreg_d;
  logic            err_q,      err_d;
  logic            in_ready_q, in_ready_d;
  logic            done_q,     done_d;
  logic [15:0]     bcd_q,      bcd_d;
  logic [27:0]     seg_q,      seg_d;         // {seg_4, seg_3, seg_2, seg_1}

  logic [SW-1:0]   adj;
  logic [SW-1:0]   shifted;

  // Active-low segment code for one decimal digit.
  function automatic logic [6:0] digit_seg(input logic [3:0] d);
    case (d)
      4'd0:    digit_seg = 7'h40;
      4'd1:    digit_seg = 7'h79;
      4'd2:    digit_seg = 7'h24;
      4'd3:    digit_seg = 7'h30;
      4'd4:    digit_seg = 7'h19;
      4'd5:    digit_seg = 7'h12;
      4'd6:    digit_seg = 7'h02;
      4'd7:    digit_seg = 7'h78;
      4'd8:    digit_seg = 7'h00;
      4'd9:    digit_seg = 7'h10;
      default: digit_seg = SEG_BLANK;
    endcase
  endfunction

  // Full four-digit display pattern for a finished BCD value.
  function automatic logic [27:0] disp_segs(input logic [15:0] b, input logic err);
    logic [6:0] s3, s2, s1, s0;
    s3 = digit_seg(b[15:12]);
    s2 = digit_seg(b[11:8]);
    s1 = digit_seg(b[7:4]);
    s0 = digit_seg(b[3:0]);
`ifdef LEADING_ZERO_BLANK_EN
    if (b[15:12] == 4'd0) s3 = SEG_BLANK;
    if (b[15:8]  == 8'd0) s2 = SEG_BLANK;
    if (b[15:4]  == 12'd0) s1 = SEG_BLANK;
`endif
    if (err) disp_segs = {SEG_E, SEG_R, SEG_R, SEG_BLANK};
    else     disp_segs = {s3, s2, s1, s0};
  endfunction

  // Next-state logic: accept in IDLE, one add-3/shift step per SHIFT cycle,
  // publish bcd/segments on the last shift.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d    = state_q;
    cnt_d      = cnt_q;
    sreg_d     = sreg_q;
    err_d      = err_q;
    in_ready_d = in_ready_q;
    done_d     = 1'b0;
    bcd_d      = bcd_q;
    seg_d      = seg_q;

    adj = sreg_q;
    for (int i = 0; i < 4; i++) begin
      if (adj[IN_WIDTH + 4*i +: 4] >= 4'd5)
        adj[IN_WIDTH + 4*i +: 4] = adj[IN_WIDTH + 4*i +: 4] + 4'd3;
    end
    shifted = {adj[SW-2:0], 1'b0};

    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          sreg_d     = {16'b0, bus.bin};
          err_d      = bus.err_in;
          cnt_d      = CW'(IN_WIDTH);
          in_ready_d = 1'b0;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        sreg_d = shifted;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          bcd_d      = shifted[SW-1 -: 16];
          seg_d      = disp_segs(shifted[SW-1 -: 16], err_q);
          done_d     = 1'b1;
          in_ready_d = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any conversion and blanks the display.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sreg_q     <= '0;
      err_q      <= 1'b0;
      in_ready_q <= 1'b1;
      done_q     <= 1'b0;
      bcd_q      <= 16'h0000;
      seg_q      <= {4{SEG_BLANK}};
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sreg_q     <= sreg_d;
      err_q      <= err_d;
      in_ready_q <= in_ready_d;
      done_q     <= done_d;
      bcd_q      <= bcd_d;
      seg_q      <= seg_d;
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.done     = done_q;
  assign bus.bcd      = bcd_q;
  assign bus.seg_4    = seg_q[27:21];
  assign bus.seg_3    = seg_q[20:14];
  assign bus.seg_2    = seg_q[13:7];
  assign bus.seg_1    = seg_q[6:0];

endmodule

// File: tb/tb_alu_seg_disp.sv
// Directed bench for alu_seg_disp: reset, full-scale value, zero, error
// pattern, back-to-back handshake, reset abort and a random sweep against
// a decimal-digit reference. Expectations follow LEADING_ZERO_BLANK_EN.
module tb_alu_seg_disp;

  localparam int W = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  alu_seg_disp_if #(.IN_WIDTH(W)) bus ();

  alu_seg_disp #(.IN_WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [15:0] exp_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [27:0] exp_segs(input int v, input bit e);
    logic [6:0] s3, s2, s1, s0;
    if (e) return {7'h06, 7'h2F, 7'h2F, 7'h7F};
    s3 = seg_of(v / 1000);
    s2 = seg_of((v / 100) % 10);
    s1 = seg_of((v / 10) % 10);
    s0 = seg_of(v % 10);
`ifdef LEADING_ZERO_BLANK_EN
    if (v < 1000) s3 = 7'h7F;
    if (v < 100)  s2 = 7'h7F;
    if (v < 10)   s1 = 7'h7F;
`endif
    return {s3, s2, s1, s0};
  endfunction

  function automatic logic [27:0] dut_segs();
    return {bus.seg_4, bus.seg_3, bus.seg_2, bus.seg_1};
  endfunction

  // One request/response: checks handshake timing, bcd and segments.
  task automatic convert(input int v, input bit e);
    int cyc;
    int low;
    cyc = 0;
    while (!bus.in_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("ready_wait", 32'(bus.in_ready), 32'd1);
    bus.bin      = W'(v);
    bus.err_in   = e;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.bin      = W'($urandom);   // must not disturb the conversion in flight
    bus.err_in   = ~e;
    cyc = 1;
    low = 0;
    while (!bus.done && cyc < 40) begin
      if (!bus.in_ready) low++;
      @(negedge clk);
      cyc++;
    end
    check("latency", 32'(cyc), 32'(W + 1));
    check("busy_cycles", 32'(low), 32'(W));
    check("bcd", 32'(bus.bcd), 32'(exp_bcd(v)));
    check("segs", 32'(dut_segs()), 32'(exp_segs(v, e)));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int seen;
    bus.bin      = '0;
    bus.err_in   = 1'b0;
    bus.in_valid = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(bus.in_ready), 32'd1);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_bcd", 32'(bus.bcd), 32'h0);
    check("rst_segs", 32'(dut_segs()), 32'(28'hFFFFFFF));
    rst_n = 1'b1;
    @(negedge clk);

    // Full-scale value, done is a single-cycle pulse
    convert(4095, 1'b0);
    check("segs_4095", 32'(dut_segs()), 32'({7'h19, 7'h40, 7'h10, 7'h12}));
    @(negedge clk);
    check("done_pulse", 32'(bus.done), 32'd0);

    // Zero, single digit and mixed values
    convert(0, 1'b0);
    convert(7, 1'b0);
    convert(40, 1'b0);
    convert(1204, 1'b0);

    // Error pattern, then recovery
    convert(37, 1'b1);
    check("err_segs", 32'(dut_segs()), 32'({7'h06, 7'h2F, 7'h2F, 7'h7F}));
    convert(37, 1'b0);

    // Back-to-back with in_valid held high
    bus.bin = W'(1234);
    bus.err_in = 1'b0;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.bin = W'(56);
    cyc = 1;
    while (!bus.done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("b2b_lat1", 32'(cyc), 32'(W + 1));
    check("b2b_bcd1", 32'(bus.bcd), 32'h1234);
    @(negedge clk);
    check("b2b_accept2", 32'(bus.in_ready), 32'd0);
    bus.bin = W'(999);
    cyc = 1;
    while (!bus.done && cyc < 40) begin
      if (cyc == 6) bus.in_valid = 1'b0;
      @(negedge clk);
      cyc++;
    end
    check("b2b_lat2", 32'(cyc), 32'(W + 1));
    check("b2b_bcd2", 32'(bus.bcd), 32'h0056);
    check("b2b_segs2", 32'(dut_segs()), 32'(exp_segs(56, 1'b0)));
    bus.in_valid = 1'b0;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.done) seen++;
    end
    check("b2b_no_extra", 32'(seen), 32'd0);

    // Reset in the middle of a conversion
    bus.bin = W'(999);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_bcd", 32'(bus.bcd), 32'h0);
    check("abort_segs", 32'(dut_segs()), 32'(28'hFFFFFFF));
    check("abort_ready", 32'(bus.in_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.done) seen++;
    end
    check("abort_no_done", 32'(seen), 32'd0);
    convert(8, 1'b0);
    check("after_abort_bcd", 32'(bus.bcd), 32'h0008);

    // Random sweep
    for (int i = 0; i < 1000; i++) begin
      convert(int'($urandom_range(4095, 0)), ($urandom_range(7, 0) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
